slc3_mem_responder: RTL and testbench



---
 rtl/slc3_mem_pkg.sv | 39 +++
 rtl/slc3_boot_rom.sv | 24 ++
 rtl/slc3_mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_slc3_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slc3_mem_pkg
//  Purpose  : Shared definitions for the SLC-3 memory responder.
//             - MMIO_ADDR    : address of the switch/hex I/O word
//             - state_e      : responder state (BOOT, SERVE)
//             - addr_class_e : address classes (RAM, MMIO, unmapped)
//             - addr_class() : classifies a 16-bit word address
//  Revision : 1.0  initial release
// ============================================================================
package slc3_mem_pkg;

    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

    typedef enum logic [0:0] {
        BOOT  = 1'b0,
        SERVE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        ACL_RAM      = 2'd0,
        ACL_MMIO     = 2'd1,
        ACL_UNMAPPED = 2'd2
    } addr_class_e;

    // MMIO takes priority so xFFFF stays I/O even with a full 64K-word RAM.
    function automatic addr_class_e addr_class(input logic [15:0] addr,
                                               input int          aw);
        if (addr == MMIO_ADDR) begin
            return ACL_MMIO;
        end
        if ((32'(addr) >> aw) == 32'd0) begin
            return ACL_RAM;
        end
        return ACL_UNMAPPED;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_boot_rom.sv
`default_nettype none
// ============================================================================
//  Module   : slc3_boot_rom
//  Purpose  : Combinational boot-image lookup. Word k of the image is
//             (k * x0101) ^ x5A00, truncated to 16 bits. Only instantiated
//             when SLC3_MEM_BOOT_EN is defined.
//  Ports    : i_k    [K_W-1:0] in   word index (boot counter)
//             o_word [15:0]    out  image word at index i_k
//  Revision : 1.0  initial release
// ============================================================================
module slc3_boot_rom #(
    parameter int K_W = 10
) (
    input  logic [K_W-1:0] i_k,
    output logic [15:0]    o_word
);

    localparam logic [15:0] c_STRIDE = 16'h0101;
    localparam logic [15:0] c_SEED   = 16'h5A00;

    assign o_word = (16'(i_k) * c_STRIDE) ^ c_SEED;

endmodule
`default_nettype wire

// File: rtl/slc3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : slc3_mem_responder
//  Purpose  : Memory-side responder for the SLC-3 core memory port.
//             Fixed-latency pipelined RAM plus one MMIO word at xFFFF
//             (reads return sw_i, writes load hex_o). Addresses outside RAM
//             and MMIO read as x0000 and ignore writes.
//             Build option SLC3_MEM_BOOT_EN: when defined, a boot image of
//             INIT_WORDS words is copied from slc3_boot_rom into RAM after
//             every reset while the core is held; when undefined the block
//             serves requests straight out of reset.
//  Ports    : clk           in   system clock
//             reset         in   synchronous, active-low
//             mem_mem_ena   in   request strobe
//             mem_wr_ena    in   1 = write, 0 = read
//             mem_addr[15:0]  in   word address
//             mem_wdata[15:0] in   write data
//             mem_rdata[15:0] out  read data, held until the next read
//             rdata_valid_o   out  one-cycle pulse when mem_rdata updates
//             sw_i[15:0]      in   board switches (read at xFFFF)
//             hex_o[15:0]     out  hex display latch (written at xFFFF)
//             cpu_hold_o      out  1 while the boot copy runs
//             init_done_o     out  sticky 1 once serving
//  Revision : 1.0  initial release
// ============================================================================
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2,
    parameter int INIT_WORDS   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        rdata_valid_o,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o,
    output logic        cpu_hold_o,
    output logic        init_done_o
);

    localparam int c_DEPTH  = 1 << ADDR_WIDTH;
    // An illegal parameter set keeps the responder mute instead of letting
    // it corrupt RAM or answer with the wrong latency.
    localparam bit c_CFG_OK = (READ_LATENCY >= 1) && (READ_LATENCY <= 4) &&
                              (INIT_WORDS >= 1) && (INIT_WORDS <= c_DEPTH);

    state_e                  r_state;
    logic [15:0]             r_ram [c_DEPTH];
    logic [15:0]             r_pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pipe_vld;

    addr_class_e             w_class;
    logic                    w_serving;
    logic                    w_rd_req;
    logic                    w_ram_we;
    logic [ADDR_WIDTH-1:0]   w_ram_waddr;
    logic [15:0]             w_ram_wdata;
    logic [15:0]             w_rd_word;
    logic [ADDR_WIDTH-1:0]   w_req_idx;

    assign w_class   = addr_class(mem_addr, ADDR_WIDTH);
    assign w_req_idx = mem_addr[ADDR_WIDTH-1:0];
    assign w_serving = (r_state == SERVE) && c_CFG_OK;
    assign w_rd_req  = reset && w_serving && mem_mem_ena && !mem_wr_ena;

`ifdef SLC3_MEM_BOOT_EN
    localparam int                 c_K_W    = (ADDR_WIDTH < 5) ? 5 : ADDR_WIDTH;
    localparam logic [c_K_W-1:0]   c_K_LAST = c_K_W'(INIT_WORDS - 1);

    logic [c_K_W-1:0] r_k;
    logic [15:0]      w_rom_word;

    slc3_boot_rom #(
        .K_W (c_K_W)
    ) u_boot_rom (
        .i_k    (r_k),
        .o_word (w_rom_word)
    );
`endif

    // ------------------------------------------------------------------
    // Control FSM: BOOT copies the image, SERVE is terminal until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef SLC3_MEM_BOOT_EN
            r_state     <= BOOT;
            r_k         <= '0;
            cpu_hold_o  <= 1'b1;
            init_done_o <= 1'b0;
`else
            r_state     <= SERVE;
            cpu_hold_o  <= 1'b0;
            init_done_o <= 1'b1;
`endif
        end else begin
`ifdef SLC3_MEM_BOOT_EN
            if (r_state == BOOT) begin
                r_k <= r_k + 1'b1;
                // Leave BOOT on the same edge that writes the last word.
                if (r_k == c_K_LAST) begin
                    r_state     <= SERVE;
                    cpu_hold_o  <= 1'b0;
                    init_done_o <= 1'b1;
                end
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Single RAM write port, shared by the boot copy and core writes.
    // Writes are blocked while reset is asserted; contents survive reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_ram_we    = reset && w_serving && mem_mem_ena && mem_wr_ena &&
                      (w_class == ACL_RAM);
        w_ram_waddr = w_req_idx;
        w_ram_wdata = mem_wdata;
`ifdef SLC3_MEM_BOOT_EN
        if (reset && (r_state == BOOT)) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_k[ADDR_WIDTH-1:0];
            w_ram_wdata = w_rom_word;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
    end

    // Read source for the request sampled this edge.
    always_comb begin
        w_rd_word = 16'h0000;
        case (w_class)
            ACL_RAM:  w_rd_word = r_ram[w_req_idx];
            ACL_MMIO: w_rd_word = sw_i;
            default:  w_rd_word = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 captures at the request edge T, the output
    // register loads at T+READ_LATENCY. Reset drops in-flight reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_req;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_data[0] <= w_rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_rdata     <= 16'h0000;
            rdata_valid_o <= 1'b0;
        end else begin
            rdata_valid_o <= r_pipe_vld[READ_LATENCY-1];
            if (r_pipe_vld[READ_LATENCY-1]) begin
                mem_rdata <= r_pipe_data[READ_LATENCY-1];
            end
        end
    end

    // MMIO hex latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hex_o <= 16'h0000;
        end else if (w_serving && mem_mem_ena && mem_wr_ena &&
                     (w_class == ACL_MMIO)) begin
            hex_o <= mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slc3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slc3_mem_responder
//  Purpose  : Self-checking bench for slc3_mem_responder (ADDR_WIDTH=10,
//             READ_LATENCY=2, INIT_WORDS=32). Works with or without
//             SLC3_MEM_BOOT_EN defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_slc3_mem_responder;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int INITW = 32;
    localparam int DEPTH = 1 << AW;
`ifdef SLC3_MEM_BOOT_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_mem_ena = 1'b0;
    logic        mem_wr_ena = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] sw_i = '0;
    logic [15:0] mem_rdata;
    logic        rdata_valid_o;
    logic [15:0] hex_o;
    logic        cpu_hold_o;
    logic        init_done_o;

    always #5 clk = ~clk;

    slc3_mem_responder #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (LAT),
        .INIT_WORDS   (INITW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_mem_ena   (mem_mem_ena),
        .mem_wr_ena    (mem_wr_ena),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .rdata_valid_o (rdata_valid_o),
        .sw_i          (sw_i),
        .hex_o         (hex_o),
        .cpu_hold_o    (cpu_hold_o),
        .init_done_o   (init_done_o)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        logic [15:0] val;
        bit          known;
    } rd_t;

    rd_t         pend[$];
    logic [15:0] m_mem [int];
    int unsigned m_edge = 0;
    logic [15:0] m_rdata = 16'h0000;
    bit          m_rdata_known = 1'b1;
    bit          m_valid = 1'b0;
    logic [15:0] m_hex = 16'h0000;
    bit          m_serving = 1'b0;
    int          m_k = 0;

    function automatic logic [15:0] rom_word(input int k);
        logic [31:0] p;
        p = k * 257;
        return p[15:0] ^ 16'h5A00;
    endfunction

    function automatic void chk(input string name, input logic [15:0] got,
                                input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, m_edge);
        end
    endfunction

    function automatic void model_edge(input bit rst_n, input bit ena, input bit wr,
                                       input logic [15:0] addr, input logic [15:0] wd,
                                       input logic [15:0] sw);
        rd_t r;
        if (!rst_n) begin
            pend.delete();
            m_valid       = 1'b0;
            m_rdata       = 16'h0000;
            m_rdata_known = 1'b1;
            m_hex         = 16'h0000;
            m_serving     = !BOOT_EN;
            m_k           = 0;
            return;
        end
        m_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == m_edge) begin
            r = pend.pop_front();
            m_valid       = 1'b1;
            m_rdata       = r.val;
            m_rdata_known = r.known;
        end
        if (!m_serving) begin
            m_mem[m_k] = rom_word(m_k);
            m_k++;
            if (m_k == INITW) m_serving = 1'b1;
        end else if (ena) begin
            r.due = m_edge + LAT;
            if (addr == 16'hFFFF) begin
                if (wr) m_hex = wd;
                else begin r.val = sw; r.known = 1'b1; pend.push_back(r); end
            end else if (int'(addr) < DEPTH) begin
                if (wr) m_mem[int'(addr)] = wd;
                else begin
                    r.known = m_mem.exists(int'(addr));
                    r.val   = r.known ? m_mem[int'(addr)] : 16'h0000;
                    pend.push_back(r);
                end
            end else if (!wr) begin
                r.val = 16'h0000; r.known = 1'b1; pend.push_back(r);
            end
        end
    endfunction

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input bit rst_n, input bit ena, input bit wr,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] sw);
        reset       = rst_n;
        mem_mem_ena = ena;
        mem_wr_ena  = wr;
        mem_addr    = addr;
        mem_wdata   = wd;
        sw_i        = sw;
        @(posedge clk);
        m_edge++;
        model_edge(rst_n, ena, wr, addr, wd, sw);
        #1;
        chk("valid", {15'd0, rdata_valid_o}, {15'd0, m_valid});
        chk("hex", hex_o, m_hex);
        chk("hold", {15'd0, cpu_hold_o}, {15'd0, !m_serving});
        chk("done", {15'd0, init_done_o}, {15'd0, m_serving});
        if (m_rdata_known) chk("rdata", mem_rdata, m_rdata);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    // Reset for two edges, then release and count cycles until serving.
    task automatic reset_and_boot(input string tag);
        int n;
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000);
        chk({tag, " rst rdata"}, mem_rdata, 16'h0000);
        chk({tag, " rst valid"}, {15'd0, rdata_valid_o}, 16'h0000);
        chk({tag, " rst hex"}, hex_o, 16'h0000);
        chk({tag, " rst hold"}, {15'd0, cpu_hold_o}, {15'd0, BOOT_EN});
        chk({tag, " rst done"}, {15'd0, init_done_o}, {15'd0, !BOOT_EN});
        n = 0;
        do begin
            idle();
            n++;
        end while (!init_done_o && n < 100);
        chk({tag, " boot cycles"}, 16'(n), BOOT_EN ? 16'(INITW) : 16'd1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          ena;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        bit          e_valid;
        logic [15:0] e_rdata;
        logic [15:0] e_hex;
    } vec_t;

    vec_t vt[29];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int pulses;
        bit rst_n, ena, wr;
        logic [15:0] addr;

        vt[0]  = '{1'b1, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0000};
        vt[4]  = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b0, 16'h1234, 16'hBEEF};
        vt[5]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 1'b0, 16'h1234, 16'hBEEF};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'hBEEF};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h00A5, 16'hBEEF};
        vt[8]  = '{1'b1, 1'b1, 16'h0000, 16'h7777, 16'h0000, 1'b0, 16'h00A5, 16'hBEEF};
        vt[9]  = '{1'b1, 1'b1, 16'h0400, 16'h5555, 16'h0000, 1'b0, 16'h00A5, 16'hBEEF};
        vt[10] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b0, 16'h00A5, 16'hBEEF};
        vt[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h00A5, 16'hBEEF};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'hBEEF};
        vt[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h7777, 16'hBEEF};
        vt[14] = '{1'b1, 1'b1, 16'h0001, 16'h0101, 16'h0000, 1'b0, 16'h7777, 16'hBEEF};
        vt[15] = '{1'b1, 1'b1, 16'h0002, 16'h0202, 16'h0000, 1'b0, 16'h7777, 16'hBEEF};
        vt[16] = '{1'b1, 1'b1, 16'h0003, 16'h0303, 16'h0000, 1'b0, 16'h7777, 16'hBEEF};
        vt[17] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h7777, 16'hBEEF};
        vt[18] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 16'h7777, 16'hBEEF};
        vt[19] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 16'h0101, 16'hBEEF};
        vt[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0202, 16'hBEEF};
        vt[21] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0303, 16'hBEEF};
        vt[22] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0303, 16'hBEEF};
        vt[23] = '{1'b1, 1'b1, 16'h03FF, 16'hABCD, 16'h0000, 1'b0, 16'h0303, 16'hBEEF};
        vt[24] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h0000, 1'b0, 16'h0303, 16'hBEEF};
        vt[25] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 16'h0303, 16'hBEEF};
        vt[26] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hABCD, 16'hBEEF};
        vt[27] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'hBEEF};
        vt[28] = '{1'b0, 1'b1, 16'hFFFF, 16'h1111, 16'h0000, 1'b0, 16'h0000, 16'hBEEF};

        // Power-up boot, then a reset ten cycles into the copy.
        reset_and_boot("boot");
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 10; i++) idle();
        reset_and_boot("midboot");

`ifdef SLC3_MEM_BOOT_EN
        // Boot image readback, back-to-back.
        for (int i = 0; i < INITW; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'(i), 16'h0000, 16'h0000);
            if (i >= LAT) chk("rom image", mem_rdata, rom_word(i - LAT));
        end
        for (int i = 0; i < LAT; i++) idle();
        chk("rom last", mem_rdata, rom_word(INITW - 1));
`endif

        // Directed vectors from a clean reset.
        reset_and_boot("table");
        for (int i = 0; i < 29; i++) begin
            step(1'b1, vt[i].ena, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].sw);
            chk($sformatf("vec%0d valid", i), {15'd0, rdata_valid_o}, {15'd0, vt[i].e_valid});
            chk($sformatf("vec%0d rdata", i), mem_rdata, vt[i].e_rdata);
            chk($sformatf("vec%0d hex", i), hex_o, vt[i].e_hex);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            ena   = ($urandom_range(0, 3) != 0);
            wr    = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: addr = 16'($urandom_range(0, 31));
                6:                addr = 16'hFFFF;
                7:                addr = 16'($urandom_range(16'h0400, 16'hFFFE));
                default:          addr = 16'($urandom_range(0, DEPTH - 1));
            endcase
            step(rst_n, ena, wr, addr, 16'($urandom()), 16'($urandom()));
        end

        // Reset with a read in flight: the read must be dropped.
        reset_and_boot("flight");
        step(1'b1, 1'b1, 1'b1, 16'h0005, 16'hC0DE, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        chk("flight rdata", mem_rdata, 16'h0000);
        chk("flight valid", {15'd0, rdata_valid_o}, 16'h0000);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (rdata_valid_o) pulses++;
        end
        chk("flight pulses", 16'(pulses), 16'd0);
        chk("flight rdata held", mem_rdata, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
